// File: rtl/qc_address_generator_pkg.sv
// Shared definitions for the LDPC burst address generator.
package ldpc_addr_pkg;

    // Burst controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Addressing modes selected at burst start.
    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_CIRC   = 1'b1;

endpackage

// File: rtl/qc_address_generator_mod_counter.sv
// Loadable counter that rolls over to zero at modulus-1.
module mod_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    // Terminal count: the next increment returns the counter to zero.
    always_comb begin
        wrap = (value == modulus - WIDTH'(1));
    end

    // Counter register: load has priority over increment; en freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= WIDTH'(RESET_VALUE);
        end else if (en) begin
            if (load) begin
                value <= load_value;
            end else if (inc) begin
                value <= wrap ? '0 : value + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/qc_address_generator.sv
// Burst address generator: linear stride or quasi-cyclic rotation.
module qc_address_generator
    import ldpc_addr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT_FROM = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] stride,
    input  logic [DATA_WIDTH-1:0] len,
    input  logic [DATA_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    state_t                state_q;
    state_t                state_d;

    logic                  mode_q;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] stride_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic                  cfg_err_q;

    logic                  start_ok;
    logic                  beat;
    logic                  shift_bad;
    logic [DATA_WIDTH-1:0] r_start;
    logic [DATA_WIDTH-1:0] first_addr;
    logic [DATA_WIDTH-1:0] next_addr;

    logic [DATA_WIDTH-1:0] idx_value;
    logic                  idx_wrap;
    logic [DATA_WIDTH-1:0] r_value;
    logic                  r_wrap;
    logic                  unused_idx;

    // Handshake qualifiers and first-address computation for a new burst.
    always_comb begin
        start_ok   = en && (state_q == ST_IDLE) && start;
        beat       = en && (state_q == ST_RUN) && addr_ready;
        shift_bad  = (shift >= len);
        r_start    = shift_bad ? '0 : shift;
        first_addr = (mode == MODE_CIRC)
                   ? base + r_start
                   : base + DATA_WIDTH'(COUNT_FROM) * stride;
        // base + ((r+1) mod len) without a divider: the counter's wrap selects offset zero.
        next_addr  = (mode_q == MODE_CIRC)
                   ? base_q + (r_wrap ? '0 : r_value + DATA_WIDTH'(1))
                   : addr_q + stride_q;
    end

    // Beat index within the burst; its terminal count marks the last beat.
    mod_counter #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (COUNT_FROM)
    ) u_idx (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (start_ok),
        .load_value ('0),
        .inc        (beat),
        .modulus    (len_q),
        .value      (idx_value),
        .wrap       (idx_wrap)
    );

    // Circulant rotating offset r, starting at the captured shift.
    mod_counter #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (0)
    ) u_rot (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (start_ok),
        .load_value (r_start),
        .inc        (beat),
        .modulus    (len_q),
        .value      (r_value),
        .wrap       (r_wrap)
    );

    assign unused_idx = ^idx_value;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition requires en.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (addr_ready && idx_wrap) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Config capture, address accumulator and sticky configuration error.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_LINEAR;
            base_q    <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            addr_q    <= DATA_WIDTH'(COUNT_FROM);
            cfg_err_q <= 1'b0;
        end else if (en) begin
            if (start_ok) begin
                mode_q   <= mode;
                base_q   <= base;
                stride_q <= stride;
                len_q    <= len;
                if (len != '0) begin
                    addr_q <= first_addr;
                end
                if ((mode == MODE_CIRC) && shift_bad) begin
                    cfg_err_q <= 1'b1;
                end
            end else if (beat && !idx_wrap) begin
                addr_q <= next_addr;
            end
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        addr       = addr_q;
        addr_valid = (state_q == ST_RUN);
        last       = (state_q == ST_RUN) && idx_wrap;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        cfg_err    = cfg_err_q;
    end

endmodule

// File: tb/tb_qc_address_generator.sv
// Self-checking bench for qc_address_generator.
module tb_qc_address_generator;

    localparam int unsigned W  = 8;
    localparam int unsigned CF = 0;

    logic         clk = 1'b0;
    logic         reset, en, start, mode, addr_ready;
    logic [W-1:0] base, stride, len, shift;
    logic [W-1:0] addr;
    logic         addr_valid, last, busy, done, cfg_err;

    qc_address_generator #(.DATA_WIDTH(W), .COUNT_FROM(CF)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .mode       (mode),
        .base       (base),
        .stride     (stride),
        .len        (len),
        .shift      (shift),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: address list precomputed from the burst rules.
    int           m_state;  // 0 idle, 1 issuing beats, 2 finishing
    int           m_len, m_idx;
    logic [W-1:0] m_addr;
    logic         m_err;
    logic [W-1:0] m_list[256];

    // Beat / done tracking.
    int           cyc = 0;
    int           beat_cnt, last_beat_cyc, done_cyc, done_pulses;
    logic [W-1:0] beat_addr[$];
    logic         beat_last[$];

    typedef struct {
        logic         mode;
        logic [W-1:0] base, stride, len, shift;
        int           n;
        logic [W-1:0] exp[8];
        logic         err;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int r0;
        if (reset) begin
            m_state = 0;
            m_addr  = W'(CF);
            m_err   = 1'b0;
        end else if (en) begin
            case (m_state)
                0: if (start) begin
                    m_len = int'(len);
                    if (mode && shift >= len) m_err = 1'b1;
                    r0 = (shift >= len) ? 0 : int'(shift);
                    for (int i = 0; i < m_len; i++) begin
                        if (mode) m_list[i] = W'(int'(base) + (r0 + i) % m_len);
                        else      m_list[i] = W'(int'(base) + (int'(CF) + i) * int'(stride));
                    end
                    if (m_len == 0) m_state = 2;
                    else begin
                        m_state = 1;
                        m_idx   = 0;
                        m_addr  = m_list[0];
                    end
                end
                1: if (addr_ready) begin
                    if (m_idx == m_len - 1) m_state = 2;
                    else begin
                        m_idx++;
                        m_addr = m_list[m_idx];
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic clear_track();
        beat_cnt = 0; last_beat_cyc = -1; done_cyc = -1; done_pulses = 0;
        beat_addr.delete();
        beat_last.delete();
    endtask

    // One clock: note a beat before the edge, advance model, compare after the edge.
    task automatic tick();
        logic [12:0] exp_o;
        if (!reset && en && addr_valid === 1'b1 && addr_ready) begin
            beat_cnt++;
            beat_addr.push_back(addr);
            beat_last.push_back(last);
            last_beat_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (done === 1'b1) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        exp_o = {m_addr, m_state == 1, (m_state == 1) && (m_idx == m_len - 1),
                 m_state != 0, m_state == 2, m_err};
        check("outputs", {19'd0, addr, addr_valid, last, busy, done, cfg_err}, {19'd0, exp_o});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic launch(input logic md, input logic [W-1:0] b, input logic [W-1:0] s,
                          input logic [W-1:0] l, input logic [W-1:0] sh);
        mode = md; base = b; stride = s; len = l; shift = sh;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 60 && done_cyc < 0; k++) tick();
        if (done_cyc < 0) check({name, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        int start_cyc;
        logic [W-1:0] snap_addr;
        logic [4:0]   snap_flags;
        logic [7:0]   got_mask, exp_mask;

        reset = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0; addr_ready = 1'b1;
        base = '0; stride = '0; len = '0; shift = '0;
        clear_track();

        vecs[0].mode = 0; vecs[0].base = 10;  vecs[0].stride = 3; vecs[0].len = 4; vecs[0].shift = 0;
        vecs[0].n = 4; vecs[0].err = 0; vecs[0].exp = '{8'd10, 8'd13, 8'd16, 8'd19, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[1].mode = 1; vecs[1].base = 64;  vecs[1].stride = 0; vecs[1].len = 8; vecs[1].shift = 5;
        vecs[1].n = 8; vecs[1].err = 0; vecs[1].exp = '{8'd69, 8'd70, 8'd71, 8'd64, 8'd65, 8'd66, 8'd67, 8'd68};
        vecs[2].mode = 0; vecs[2].base = 250; vecs[2].stride = 4; vecs[2].len = 3; vecs[2].shift = 0;
        vecs[2].n = 3; vecs[2].err = 0; vecs[2].exp = '{8'd250, 8'd254, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[3].mode = 1; vecs[3].base = 32;  vecs[3].stride = 0; vecs[3].len = 8; vecs[3].shift = 9;
        vecs[3].n = 8; vecs[3].err = 1; vecs[3].exp = '{8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39};
        vecs[4].mode = 0; vecs[4].base = 7;   vecs[4].stride = 1; vecs[4].len = 0; vecs[4].shift = 0;
        vecs[4].n = 0; vecs[4].err = 0; vecs[4].exp = '{default: 8'd0};
        vecs[5].mode = 1; vecs[5].base = 100; vecs[5].stride = 0; vecs[5].len = 1; vecs[5].shift = 0;
        vecs[5].n = 1; vecs[5].err = 0; vecs[5].exp = '{8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        // Table-driven bursts with ready held high.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            check($sformatf("vec%0d_rst_addr", v), {24'd0, addr}, CF);
            check($sformatf("vec%0d_rst_flags", v), {27'd0, addr_valid, last, busy, done, cfg_err}, 0);
            clear_track();
            start_cyc = cyc;
            launch(vecs[v].mode, vecs[v].base, vecs[v].stride, vecs[v].len, vecs[v].shift);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_beats", v), beat_cnt, vecs[v].n);
            got_mask = '0;
            for (int i = 0; i < vecs[v].n && i < beat_addr.size(); i++) begin
                check($sformatf("vec%0d_addr%0d", v, i), {24'd0, beat_addr[i]}, {24'd0, vecs[v].exp[i]});
                got_mask[i] = beat_last[i];
            end
            exp_mask = '0;
            if (vecs[v].n > 0) exp_mask[vecs[v].n - 1] = 1'b1;
            check($sformatf("vec%0d_last_mask", v), {24'd0, got_mask}, {24'd0, exp_mask});
            check($sformatf("vec%0d_done_cycle", v), done_cyc,
                  (vecs[v].n == 0) ? start_cyc + 1 : last_beat_cyc + 1);
            check($sformatf("vec%0d_cfg_err", v), {31'd0, cfg_err}, {31'd0, vecs[v].err});
            tick();
            check($sformatf("vec%0d_done_pulse", v), done_pulses, 1);
            check($sformatf("vec%0d_idle", v), {31'd0, busy}, 0);
        end

        // Backpressure: ready alternates; address holds while ready is low.
        do_reset();
        clear_track();
        launch(0, 250, 4, 3, 0);
        for (int k = 0; k < 30 && done_cyc < 0; k++) begin
            addr_ready = k[0];
            snap_addr = addr;
            tick();
            if (!addr_ready && busy && !done) check("bp_hold", {24'd0, addr}, {24'd0, snap_addr});
        end
        addr_ready = 1'b1;
        check("bp_beats", beat_cnt, 3);
        if (beat_addr.size() == 3)
            check("bp_seq", {8'd0, beat_addr[0], beat_addr[1], beat_addr[2]}, {8'd0, 8'd250, 8'd254, 8'd2});

        // Enable freeze mid-burst, with a start pulse that must be ignored.
        do_reset();
        clear_track();
        launch(1, 64, 0, 8, 5);
        tick(); tick();
        snap_addr  = addr;
        snap_flags = {addr_valid, last, busy, done, cfg_err};
        en = 1'b0; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("freeze_addr", {24'd0, addr}, {24'd0, snap_addr});
            check("freeze_flags", {27'd0, addr_valid, last, busy, done, cfg_err}, {27'd0, snap_flags});
        end
        en = 1'b1;
        tick();
        start = 1'b0;
        wait_done("freeze");
        check("freeze_beats", beat_cnt, 8);
        if (beat_addr.size() == 8) begin
            check("freeze_seq_lo", {beat_addr[0], beat_addr[1], beat_addr[2], beat_addr[3]}, {8'd69, 8'd70, 8'd71, 8'd64});
            check("freeze_seq_hi", {beat_addr[4], beat_addr[5], beat_addr[6], beat_addr[7]}, {8'd65, 8'd66, 8'd67, 8'd68});
        end
        tick(); tick();
        check("freeze_no_restart", {31'd0, busy}, 0);

        // Reset during the third beat: no done, clean restart afterwards.
        do_reset();
        clear_track();
        launch(0, 5, 1, 6, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_addr", {24'd0, addr}, CF);
        check("midrst_flags", {27'd0, addr_valid, last, busy, done, cfg_err}, 0);
        for (int k = 0; k < 4; k++) tick();
        check("midrst_no_done", done_pulses, 0);
        clear_track();
        launch(0, 10, 3, 4, 0);
        wait_done("midrst_restart");
        check("midrst_restart_beats", beat_cnt, 4);
        if (beat_addr.size() == 4)
            check("midrst_restart_seq", {beat_addr[0], beat_addr[1], beat_addr[2], beat_addr[3]}, {8'd10, 8'd13, 8'd16, 8'd19});

        // Back-to-back: start held high gives a done every len+2 cycles.
        do_reset();
        clear_track();
        mode = 0; base = 20; stride = 2; len = 2; shift = 0;
        start = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        start = 1'b0;
        check("b2b_done_pulses", done_pulses, 3);
        check("b2b_beats", beat_cnt, 6);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset      = ($urandom_range(0, 59) == 0);
            en         = ($urandom_range(0, 9) < 8);
            start      = ($urandom_range(0, 9) < 3);
            addr_ready = ($urandom_range(0, 9) < 7);
            mode       = $urandom_range(0, 1);
            base       = W'($urandom);
            stride     = W'($urandom);
            len        = W'($urandom_range(0, 9));
            shift      = W'($urandom_range(0, 10));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
